// File: rtl/register_flags_stack.sv
// Processor flags register with per-bit masked writes and a push/pop save stack.
// Optional sticky overflow flag built only when FLAGS_STICKY_OVF_EN is defined.
module register_flags_stack #(
  parameter int NFLAGS  = 4,
  parameter int DEPTH   = 4,
  parameter int OVF_BIT = 3
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [NFLAGS-1:0]          in_F,
  input  logic [NFLAGS-1:0]          W_MASK,
  input  logic                       PUSH,
  input  logic                       POP,
  input  logic                       ERR_CLR,
  output logic [NFLAGS-1:0]          out_F,
  output logic [$clog2(DEPTH+1)-1:0] CNT,
  output logic                       FULL,
  output logic                       EMPTY,
  output logic                       ERR
`ifdef FLAGS_STICKY_OVF_EN
  ,
  input  logic                       SO_CLR,
  output logic                       out_SO
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  generate
    if (DEPTH < 1 || OVF_BIT < 0 || OVF_BIT >= NFLAGS) begin : g_param_check
      $error("register_flags_stack: illegal DEPTH or OVF_BIT");
    end
  endgenerate

  logic [NFLAGS-1:0] r_flags;
  logic [CW-1:0]     r_cnt;
  logic              r_err;
  logic [NFLAGS-1:0] r_stack [DEPTH];

  logic              w_full;
  logic              w_empty;
  logic              w_do_push;
  logic              w_do_pop;
  logic              w_do_xchg;
  logic              w_stack_err;
  logic [AW-1:0]     w_push_idx;
  logic [AW-1:0]     w_top_idx;
  logic [NFLAGS-1:0] w_base;
  logic [NFLAGS-1:0] w_flags_nxt;
  logic [CW-1:0]     w_cnt_nxt;
  logic              w_err_nxt;

  // Occupancy decode and operation classification.
  always_comb begin
    w_full      = (r_cnt == CW'(DEPTH));
    w_empty     = (r_cnt == {CW{1'b0}});
    w_do_push   = PUSH & ~POP & ~w_full;
    w_do_pop    = POP & ~PUSH & ~w_empty;
    w_do_xchg   = PUSH & POP & ~w_empty;
    w_stack_err = (PUSH & ~POP & w_full) | (POP & w_empty);
    w_push_idx  = AW'(r_cnt);
    w_top_idx   = AW'(r_cnt - CW'(1));
  end

  // Next flags, count and error; masked write bits override any restored value.
  always_comb begin
    w_base      = r_flags;
    w_flags_nxt = r_flags;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;

    if (w_do_pop || w_do_xchg) begin
      w_base = r_stack[w_top_idx];
    end else begin
      w_base = r_flags;
    end
    w_flags_nxt = (w_base & ~W_MASK) | (in_F & W_MASK);

    if (w_do_push) begin
      w_cnt_nxt = r_cnt + CW'(1);
    end else if (w_do_pop) begin
      w_cnt_nxt = r_cnt - CW'(1);
    end else begin
      w_cnt_nxt = r_cnt;
    end

    // A new error beats a same-cycle clear.
    if (w_stack_err) begin
      w_err_nxt = 1'b1;
    end else if (ERR_CLR) begin
      w_err_nxt = 1'b0;
    end else begin
      w_err_nxt = r_err;
    end
  end

  // Flags, count and error state registers.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_flags <= {NFLAGS{1'b0}};
      r_cnt   <= {CW{1'b0}};
      r_err   <= 1'b0;
    end else begin
      r_flags <= w_flags_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Stack storage is deliberately not reset; the pre-edge flags are saved.
  always_ff @(posedge CLK) begin
    if (RST_N && w_do_push) begin
      r_stack[w_push_idx] <= r_flags;
    end else if (RST_N && w_do_xchg) begin
      r_stack[w_top_idx] <= r_flags;
    end
  end

`ifdef FLAGS_STICKY_OVF_EN
  logic r_so;

  // Sticky overflow: any written O=1 sets it and wins over a same-cycle clear.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_so <= 1'b0;
    end else if (W_MASK[OVF_BIT] && in_F[OVF_BIT]) begin
      r_so <= 1'b1;
    end else if (SO_CLR) begin
      r_so <= 1'b0;
    end else begin
      r_so <= r_so;
    end
  end

  assign out_SO = r_so;
`endif

  assign out_F = r_flags;
  assign CNT   = r_cnt;
  assign FULL  = w_full;
  assign EMPTY = w_empty;
  assign ERR   = r_err;

endmodule
